mii_mac_tx: RTL and testbench
=============================

Name: mii_mac_tx

Overview:
- MII transmit MAC: accepts a byte stream from the TX buffer and drives the 4-bit PHY transmit interface.
- Generates preamble and SFD, sends data low nibble first, pads to minimum size, appends CRC-32 FCS and enforces the inter-frame gap.
- Transmit-direction counterpart of the MII receive path that feeds the RX FIFO. Full duplex only; CRS/COL are not used.

Parameters:
- MIN_FRAME, 60, minimum frame length in bytes (DA through payload, FCS excluded) after padding.
- PAD_EN, 1, 1 = zero-pad short frames to MIN_FRAME; 0 = no padding.
- IFG_NIBBLES, 24, idle nibble-times after FCS before the next preamble (24 = 96 bit times).

Ports:
- phy_tx_clk  in  1  MII TX clock; the only clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- tx_mac_data  in  8  byte from TX buffer.
- tx_mac_valid  in  1  tx_mac_data is valid.
- tx_mac_last  in  1  qualifies the final byte of the frame.
- tx_mac_ready  out  1  byte is consumed this cycle when tx_mac_valid=1.
- phy_tx_en  out  1  MII TX_EN, registered.
- phy_txd  out  4  MII TXD, registered.
- phy_tx_err  out  1  MII TX_ER, registered.
- tx_done  out  1  one-cycle pulse on the cycle after the last FCS nibble.
- tx_underrun  out  1  one-cycle pulse when an underrun aborts the frame.

Behaviour:
- Reset values:
  - phy_tx_en=0, phy_txd=0, phy_tx_err=0, tx_mac_ready=0, tx_done=0, tx_underrun=0.
  - State = IDLE, counters = 0, CRC = 32'hFFFFFFFF.
  - Reset mid-frame ends the frame immediately: tx_en drops on the next edge and no FCS is sent.
- IDLE:
  - On tx_mac_valid=1 go to PRE, nibble counter = 0, CRC = FFFFFFFF.
  - First phy_tx_en=1 appears on the edge after valid is sampled (1-cycle latency).
- PRE:
  - 15 nibbles of 4'h5, then 4'hD (SFD byte D5 = 5,D).
  - tx_mac_ready=1 combinationally during the SFD nibble cycle to fetch data byte 0.
- DATA:
  - Each accepted byte is sent in 2 cycles: [3:0] first, then [7:4].
  - tx_mac_ready=1 during the high-nibble cycle of the current byte, unless that byte had last=1.
  - The CRC updates once per byte with the reflected polynomial 32'hEDB88320, LSB first. A per-nibble update is allowed if the results are identical.
  - The byte counter (11 bits, saturating at 2047) increments per byte sent.
- Last data byte:
  - If PAD_EN=1 and byte count < MIN_FRAME, go to PAD; otherwise go to FCS.
- PAD:
  - Send 8'h00 bytes through the CRC until count = MIN_FRAME, then go to FCS.
  - tx_mac_ready=0 throughout.
- FCS:
  - Send ~CRC as 8 nibbles, bits [3:0] first, ascending.
  - After the final nibble: tx_en=0, tx_done pulses, go to IFG.
- IFG:
  - Hold tx_en=0 for IFG_NIBBLES cycles; tx_mac_ready=0 and valid is ignored.
  - Then go to IDLE. A valid already high is taken on the IDLE cycle.
- Underrun:
  - Occurs when tx_mac_ready=1 and tx_mac_valid=0 in PRE(SFD) or DATA.
  - Next nibble cycle: phy_tx_en=1, phy_tx_err=1, txd=0 for one cycle, and tx_underrun pulses.
  - Then tx_en=0, no FCS, go to IFG.
- Other rules:
  - tx_mac_last is only sampled with an accepted byte.
  - tx_mac_data must not change while valid=1 and ready=0.
  - phy_tx_err=0 at all other times.

Test Plan:
- PAD_EN=0, 9-byte frame "123456789" (31..39) -> 15×5, D, then nibbles 1,3,2,3,…,9,3, then FCS 6,2,9,3,4,F,B,C (CRC CBF43926). tx_en high for 42 cycles; tx_done one cycle after the last nibble.
- PAD_EN=1, 14-byte header-only frame -> 46 zero bytes inserted (120 data nibbles). tx_en high for 16+120+8=144 cycles. FCS matches the bench reference CRC over the 60 bytes.
- 64-byte frame with tx_mac_valid held high, followed immediately by a second frame -> exactly 24 cycles of tx_en=0 between frames. tx_mac_ready pulses exactly 64 times per frame.
- Deassert tx_mac_valid at data byte 20 -> one cycle of tx_en=1/tx_err=1/txd=0, tx_underrun pulse, no FCS, 24 idle cycles, then accepts a new frame.
- Assert reset during FCS nibble 3 -> next edge: tx_en=0, all outputs 0. A frame started after reset deasserts is correct (CRC reinitialised).
- Single-byte frame with last=1 on byte 0, PAD_EN=1 -> 59 pad bytes. Ready asserts only during the SFD cycle.

Source files
------------

// File: rtl/mii_mac_tx_if.sv
// Byte-stream handshake between the TX buffer and the MII transmit MAC.
// master = TX buffer side (drives data/valid/last), slave = MAC side (drives ready).
// A byte moves on a rising edge where tx_mac_valid and tx_mac_ready are both high.
interface mii_mac_tx_if;
    logic [7:0] tx_mac_data;
    logic       tx_mac_valid;
    logic       tx_mac_last;
    logic       tx_mac_ready;

    modport master (
        output tx_mac_data,
        output tx_mac_valid,
        output tx_mac_last,
        input  tx_mac_ready
    );

    modport slave (
        input  tx_mac_data,
        input  tx_mac_valid,
        input  tx_mac_last,
        output tx_mac_ready
    );
endinterface

// File: rtl/mii_mac_tx.sv
// MII transmit MAC: preamble/SFD, low-nibble-first data, zero padding, CRC-32 FCS, inter-frame gap.
// Latency: first TX_EN one edge after the IDLE cycle that samples valid; PHY outputs are registered.
// Backpressure: ready is combinational, high only on the SFD cycle and on high-nibble cycles of non-last bytes.
//
// Ports:
//   phy_tx_clk            - MII TX clock, the only clock
//   reset                 - synchronous, active-high
//   tx_mac (slave)        - byte stream from the TX buffer (data/valid/last in, ready out)
//   phy_tx_en/txd/tx_err  - registered MII transmit pins
//   tx_done               - one-cycle pulse on the cycle after the last FCS nibble
//   tx_underrun           - one-cycle pulse, coincident with the TX_ER nibble of an aborted frame
module mii_mac_tx #(
    parameter int MIN_FRAME   = 60,
    parameter int PAD_EN      = 1,
    parameter int IFG_NIBBLES = 24
) (
    input  logic          phy_tx_clk,
    input  logic          reset,
    mii_mac_tx_if.slave   tx_mac,
    output logic          phy_tx_en,
    output logic [3:0]    phy_txd,
    output logic          phy_tx_err,
    output logic          tx_done,
    output logic          tx_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_UNDR,
        S_IFG
    } state_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    // The IDLE cycle that picks up a waiting frame also emits an idle nibble,
    // so the IFG state itself lasts one cycle less than the gap seen on the pins.
    localparam logic [15:0] IFG_LAST = 16'((IFG_NIBBLES >= 2) ? (IFG_NIBBLES - 2) : 0);

    // Reflected CRC-32 (poly EDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] nib_q, nib_d;          // preamble / FCS / IFG counter; bit 0 = high nibble in DATA/PAD
    logic [7:0]  byte_q, byte_d;        // byte currently on the wire
    logic        last_q, last_d;        // byte_q carried tx_mac_last
    logic [10:0] cnt_q, cnt_d;          // bytes sent (DA..payload/pad), saturating
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  txd_q, txd_d;
    logic        tx_err_q, tx_err_d;
    logic        done_pend_q, done_pend_d;
    logic        tx_done_q, tx_done_d;
    logic        tx_underrun_q, tx_underrun_d;
    logic        rdy;

    logic [10:0] cnt_inc;
    logic [31:0] crc_nxt;
    logic [31:0] fcs;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;
    assign crc_nxt = crc_byte(crc_q, (state_q == S_PAD) ? 8'h00 : byte_q);
    assign fcs     = ~crc_q;

    always_comb begin
        state_d       = state_q;
        nib_d         = nib_q;
        byte_d        = byte_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        crc_d         = crc_q;
        tx_en_d       = 1'b0;
        txd_d         = 4'h0;
        tx_err_d      = 1'b0;
        done_pend_d   = 1'b0;
        tx_done_d     = done_pend_q;
        tx_underrun_d = 1'b0;
        rdy           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_mac.tx_mac_valid) begin
                    state_d = S_PRE;
                    nib_d   = 16'd0;
                    cnt_d   = 11'd0;
                    crc_d   = 32'hFFFF_FFFF;
                end
            end

            S_PRE: begin
                tx_en_d = 1'b1;
                if (nib_q == 16'd15) begin
                    // SFD nibble: fetch data byte 0 now so it follows without a bubble.
                    txd_d = 4'hD;
                    rdy   = 1'b1;
                    nib_d = 16'd0;
                    if (tx_mac.tx_mac_valid) begin
                        byte_d  = tx_mac.tx_mac_data;
                        last_d  = tx_mac.tx_mac_last;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_UNDR;
                    end
                end else begin
                    txd_d = 4'h5;
                    nib_d = nib_q + 16'd1;
                end
            end

            S_DATA: begin
                tx_en_d = 1'b1;
                if (!nib_q[0]) begin
                    txd_d = byte_q[3:0];
                    nib_d = 16'd1;
                end else begin
                    txd_d = byte_q[7:4];
                    nib_d = 16'd0;
                    crc_d = crc_nxt;
                    cnt_d = cnt_inc;
                    if (last_q) begin
                        state_d = ((PAD_EN != 0) && (cnt_inc < MIN_CNT)) ? S_PAD : S_FCS;
                    end else begin
                        rdy = 1'b1;
                        if (tx_mac.tx_mac_valid) begin
                            byte_d = tx_mac.tx_mac_data;
                            last_d = tx_mac.tx_mac_last;
                        end else begin
                            state_d = S_UNDR;
                        end
                    end
                end
            end

            S_PAD: begin
                tx_en_d = 1'b1;
                if (!nib_q[0]) begin
                    nib_d = 16'd1;
                end else begin
                    nib_d = 16'd0;
                    crc_d = crc_nxt;
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        state_d = S_FCS;
                    end
                end
            end

            S_FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{nib_q[2:0], 2'b00} +: 4];
                if (nib_q[2:0] == 3'd7) begin
                    nib_d       = 16'd0;
                    done_pend_d = 1'b1;
                    state_d     = S_IFG;
                end else begin
                    nib_d = nib_q + 16'd1;
                end
            end

            S_UNDR: begin
                // Single TX_ER nibble marks the truncated frame for the PHY.
                tx_en_d       = 1'b1;
                tx_err_d      = 1'b1;
                tx_underrun_d = 1'b1;
                nib_d         = 16'd0;
                state_d       = S_IFG;
            end

            S_IFG: begin
                if (nib_q >= IFG_LAST) begin
                    nib_d   = 16'd0;
                    state_d = S_IDLE;
                end else begin
                    nib_d = nib_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                nib_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge phy_tx_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            nib_q         <= 16'd0;
            byte_q        <= 8'h00;
            last_q        <= 1'b0;
            cnt_q         <= 11'd0;
            crc_q         <= 32'hFFFF_FFFF;
            tx_en_q       <= 1'b0;
            txd_q         <= 4'h0;
            tx_err_q      <= 1'b0;
            done_pend_q   <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            nib_q         <= nib_d;
            byte_q        <= byte_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            crc_q         <= crc_d;
            tx_en_q       <= tx_en_d;
            txd_q         <= txd_d;
            tx_err_q      <= tx_err_d;
            done_pend_q   <= done_pend_d;
            tx_done_q     <= tx_done_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is consumed mid-reset.
    assign tx_mac.tx_mac_ready = rdy & ~reset;
    assign phy_tx_en           = tx_en_q;
    assign phy_txd             = txd_q;
    assign phy_tx_err          = tx_err_q;
    assign tx_done             = tx_done_q;
    assign tx_underrun         = tx_underrun_q;

endmodule

// File: tb/tb_mii_mac_tx.sv
// Self-checking bench for mii_mac_tx: one instance without padding, one with padding.
// Frame-level vectors come from a table; back-to-back and mid-FCS reset are hand-written sequences.
module tb_mii_mac_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mii_mac_tx_if if0();
    mii_mac_tx_if if1();

    logic       en0, en1, err0, err1, done0, done1, un0, un1;
    logic [3:0] txd0, txd1;

    mii_mac_tx #(.MIN_FRAME(60), .PAD_EN(0), .IFG_NIBBLES(24)) dut0 (
        .phy_tx_clk (clk),
        .reset      (reset),
        .tx_mac     (if0),
        .phy_tx_en  (en0),
        .phy_txd    (txd0),
        .phy_tx_err (err0),
        .tx_done    (done0),
        .tx_underrun(un0)
    );

    mii_mac_tx #(.MIN_FRAME(60), .PAD_EN(1), .IFG_NIBBLES(24)) dut1 (
        .phy_tx_clk (clk),
        .reset      (reset),
        .tx_mac     (if1),
        .phy_tx_en  (en1),
        .phy_txd    (txd1),
        .phy_tx_err (err1),
        .tx_done    (done1),
        .tx_underrun(un1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor (selected DUT) ----------------
    int         mon_sel = 0;
    logic [4:0] cap_q[$];
    logic [4:0] exp_q[$];
    int en_cnt, rdy_cnt, done_cnt, done_ok, undr_cnt, zero_run, last_gap;
    bit seen_en, prev_en;

    always @(negedge clk) begin
        logic m_en, m_err, m_rdy, m_done, m_un;
        logic [3:0] m_txd;
        m_en   = (mon_sel == 0) ? en0   : en1;
        m_err  = (mon_sel == 0) ? err0  : err1;
        m_txd  = (mon_sel == 0) ? txd0  : txd1;
        m_rdy  = (mon_sel == 0) ? if0.tx_mac_ready : if1.tx_mac_ready;
        m_done = (mon_sel == 0) ? done0 : done1;
        m_un   = (mon_sel == 0) ? un0   : un1;
        if (m_done) begin
            done_cnt++;
            if (!m_en && prev_en) done_ok++;
        end
        if (m_un) undr_cnt++;
        if (m_rdy) rdy_cnt++;
        if (m_en) begin
            cap_q.push_back({m_err, m_txd});
            en_cnt++;
            if (!prev_en && seen_en) last_gap = zero_run;
            zero_run = 0;
            seen_en  = 1'b1;
        end else begin
            zero_run++;
        end
        prev_en = m_en;
    end

    task automatic clear_mon();
        cap_q.delete();
        exp_q.delete();
        en_cnt = 0; rdy_cnt = 0; done_cnt = 0; done_ok = 0; undr_cnt = 0; last_gap = -1;
    endtask

    task automatic select(input int s);
        mon_sel = s; seen_en = 1'b0; prev_en = 1'b0; zero_run = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build_exp(input int n, input int base, input int step, input int stop_at, input bit pad_en);
        logic [31:0] c;
        logic [7:0]  b;
        int len;
        c = 32'hFFFF_FFFF;
        repeat (15) exp_q.push_back(5'h05);
        exp_q.push_back(5'h0D);
        len = (stop_at >= 0) ? stop_at : n;
        for (int i = 0; i < len; i++) begin
            b = 8'(base + i * step);
            exp_q.push_back({1'b0, b[3:0]});
            exp_q.push_back({1'b0, b[7:4]});
            c = ref_crc(c, b);
        end
        if (stop_at >= 0) begin
            exp_q.push_back(5'h10);
        end else begin
            if (pad_en) begin
                while (len < 60) begin
                    exp_q.push_back(5'h00);
                    exp_q.push_back(5'h00);
                    c = ref_crc(c, 8'h00);
                    len++;
                end
            end
            c = ~c;
            for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, c[4*k +: 4]});
        end
    endtask

    task automatic cmp_stream(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= cap_q.size() || cap_q[i] !== exp_q[i])) bad = i;
        end
        if (bad < 0 && cap_q.size() != exp_q.size()) bad = exp_q.size();
        n_cmp++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s_stream: first difference at nibble %0d, got %0h, expected %0h (len %0d vs %0d)",
                     name, bad, (bad < cap_q.size()) ? cap_q[bad] : 5'h1F,
                     (bad < exp_q.size()) ? exp_q[bad] : 5'h1F, cap_q.size(), exp_q.size());
        end
    endtask

    // ---------------- drivers ----------------
    task automatic set_in(input int sel, input bit v, input logic [7:0] d, input bit l);
        if (sel == 0) begin
            if0.tx_mac_valid = v; if0.tx_mac_data = d; if0.tx_mac_last = l;
        end else begin
            if1.tx_mac_valid = v; if1.tx_mac_data = d; if1.tx_mac_last = l;
        end
    endtask

    task automatic drive(input int sel, input int n, input int base, input int step,
                         input int stop_at, input bit keep);
        int  b;
        bit  got;
        for (int i = 0; i < n; i++) begin
            if (i == stop_at) begin
                set_in(sel, 1'b0, 8'h00, 1'b0);
                b = 0;
                while (undr_cnt == 0 && b < 300) begin @(negedge clk); #1; b++; end
                return;
            end
            set_in(sel, 1'b1, 8'(base + i * step), (i == n - 1));
            got = 1'b0;
            b = 0;
            while (!got && b < 300) begin
                @(negedge clk);
                got = (sel == 0) ? if0.tx_mac_ready : if1.tx_mac_ready;
                b++;
            end
            if (!got) begin
                n_cmp++; n_err++;
                $display("FAIL ready_wait: byte %0d never accepted, got ready=0, expected ready=1", i);
                set_in(sel, 1'b0, 8'h00, 1'b0);
                return;
            end
            @(posedge clk); #1;
        end
        if (keep) set_in(sel, 1'b1, 8'(base), 1'b0);
        else      set_in(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_end(input int target, input string name);
        int b;
        b = 0;
        while ((done_cnt + undr_cnt) < target && b < 3000) begin @(negedge clk); #1; b++; end
        if ((done_cnt + undr_cnt) < target) begin
            n_cmp++; n_err++;
            $display("FAIL %s_end: got %0d end events, expected %0d", name, done_cnt + undr_cnt, target);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          sel;
        int          n;
        int          base;
        int          step;
        int          stop_at;
        int          exp_en;
        int          exp_rdy;
        int          exp_done;
        int          exp_undr;
        bit          chk_gap;
        bit          chk_fcs;
        logic [31:0] exp_fcs;
    } vec_t;

    vec_t vt[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] fcs;
        int          sz;
        int          b;

        //          sel  n  base  step stop en  rdy done undr gap fcs  exp_fcs
        vt[0] = '{0,   9, 'h31, 1,    -1,  42,  9,  1,   0,   0,  1, 32'hCBF43926};
        vt[1] = '{1,  14, 'hA0, 'h13, -1, 144, 14,  1,   0,   0,  0, 32'h0};
        vt[2] = '{1,   1, 'h5A, 1,    -1, 144,  1,  1,   0,   1,  0, 32'h0};
        vt[3] = '{1,  40, 'h11, 'h25, 20,  57, 21,  0,   1,   1,  0, 32'h0};
        vt[4] = '{1, 100, 'h07, 'h0B, -1, 224,100,  1,   0,   1,  0, 32'h0};

        reset = 1'b1;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        select(0);
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {en0, txd0, err0, if0.tx_mac_ready, done0, un0}, 0);
        check("reset_dut1", {en1, txd1, err1, if1.tx_mac_ready, done1, un1}, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            if (i == 0 || vt[i].sel != vt[i-1].sel) select(vt[i].sel);
            clear_mon();
            build_exp(vt[i].n, vt[i].base, vt[i].step, vt[i].stop_at, vt[i].sel == 1);
            drive(vt[i].sel, vt[i].n, vt[i].base, vt[i].step, vt[i].stop_at, 1'b0);
            wait_end(1, $sformatf("v%0d", i));
            check($sformatf("v%0d_tx_en_cycles", i), en_cnt, vt[i].exp_en);
            check($sformatf("v%0d_ready_pulses", i), rdy_cnt, vt[i].exp_rdy);
            check($sformatf("v%0d_done_after_last", i), done_ok, vt[i].exp_done);
            check($sformatf("v%0d_underrun", i), undr_cnt, vt[i].exp_undr);
            cmp_stream($sformatf("v%0d", i));
            if (vt[i].chk_gap) check($sformatf("v%0d_gap", i), last_gap, 24);
            if (vt[i].chk_fcs) begin
                for (int k = 0; k < 8; k++) fcs[4*k +: 4] = cap_q[34 + k][3:0];
                check($sformatf("v%0d_fcs", i), fcs, vt[i].exp_fcs);
            end
        end

        // Two 64-byte frames with valid never dropping between them.
        clear_mon();
        build_exp(64, 'h3C, 'h07, -1, 1'b1);
        build_exp(64, 'h3C, 'h07, -1, 1'b1);
        drive(1, 64, 'h3C, 'h07, -1, 1'b1);
        drive(1, 64, 'h3C, 'h07, -1, 1'b0);
        wait_end(2, "b2b");
        check("b2b_tx_en_cycles", en_cnt, 304);
        check("b2b_ready_pulses", rdy_cnt, 128);
        check("b2b_done", done_ok, 2);
        check("b2b_gap", last_gap, 24);
        cmp_stream("b2b");

        // Reset while FCS nibble 3 is on the pins.
        repeat (30) @(posedge clk);
        #1;
        clear_mon();
        drive(1, 9, 'h31, 1, -1, 1'b0);
        b = 0;
        while (cap_q.size() < 140 && b < 500) begin @(negedge clk); #1; b++; end
        check("rst_reached_fcs3", cap_q.size(), 140);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_outputs_zero", {en1, txd1, err1, if1.tx_mac_ready, done1, un1}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        sz = cap_q.size();
        check("rst_no_more_nibbles", sz, 140);
        check("rst_no_done", done_cnt, 0);

        clear_mon();
        build_exp(9, 'hC3, 'h05, -1, 1'b1);
        drive(1, 9, 'hC3, 'h05, -1, 1'b0);
        wait_end(1, "post_rst");
        check("post_rst_tx_en_cycles", en_cnt, 144);
        check("post_rst_done", done_ok, 1);
        cmp_stream("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
